// File: rtl/memory_arbiter.sv
// Shares the single main-memory port between the instruction L1 (I) and data L1 (D).
// D has priority; a streak counter forces an I grant after MAX_DATA_STREAK D grants while I waits.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no owner; grant decision taken at the next edge, strobes low
// BUSY_I  | I-cache owns the memory port, signals pass straight through
// BUSY_D  | D-cache owns the memory port, signals pass straight through
// RELEASE | one bubble with strobes low so memory sees a fresh request edge
module memory_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int STREAK_W        = 3
) (
  input  logic        clk,
  input  logic        resetN,

  input  logic [31:0] iAddress,
  input  logic        iReadEnable,
  input  logic        iWriteEnable,
  input  logic [31:0] iDataIn,
  output logic [31:0] iDataOut,
  output logic        iReady,

  input  logic [31:0] dAddress,
  input  logic        dReadEnable,
  input  logic        dWriteEnable,
  input  logic [31:0] dDataIn,
  output logic [31:0] dDataOut,
  output logic        dReady,

  output logic [31:0] memoryAddress,
  output logic        memoryReadEnable,
  output logic        memoryWriteEnable,
  output logic [31:0] memoryDataOut,
  input  logic [31:0] memoryDataIn,
  input  logic        memoryReady,

  output logic        grantD
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_I  = 2'd1;
  localparam logic [1:0] BUSY_D  = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  logic [1:0]          state;
  logic [1:0]          nextState;
  logic [STREAK_W-1:0] streak;
  logic [STREAK_W-1:0] nextStreak;
  logic                reqI;
  logic                reqD;
  logic                starveI;

  assign reqI    = iReadEnable | iWriteEnable;
  assign reqD    = dReadEnable | dWriteEnable;
  assign starveI = reqI && (streak == STREAK_MAX);

  // Read data is broadcast; only the ready strobe qualifies it.
  assign iDataOut = memoryDataIn;
  assign dDataOut = memoryDataIn;

  always_comb begin
    nextState  = state;
    nextStreak = streak;
    case (state)
      IDLE: begin
        if (reqD && !starveI) begin
          nextState = BUSY_D;
          if (reqI)
            nextStreak = (streak == STREAK_MAX) ? STREAK_MAX : streak + 1'b1;
          else
            nextStreak = '0;
        end else if (reqI) begin
          nextState  = BUSY_I;
          nextStreak = '0;
        end
      end
      BUSY_I:  if (!reqI || memoryReady) nextState = RELEASE;
      BUSY_D:  if (!reqD || memoryReady) nextState = RELEASE;
      RELEASE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= nextState;
      streak <= nextStreak;
    end
  end

  // Outputs are also gated by resetN so a transfer in flight is cut off during reset.
  always_comb begin
    memoryAddress     = '0;
    memoryReadEnable  = 1'b0;
    memoryWriteEnable = 1'b0;
    memoryDataOut     = '0;
    iReady            = 1'b0;
    dReady            = 1'b0;
    grantD            = 1'b0;
    if (resetN) begin
      case (state)
        BUSY_I: begin
          memoryAddress     = iAddress;
          memoryReadEnable  = iReadEnable;
          memoryWriteEnable = iWriteEnable;
          memoryDataOut     = iDataIn;
          iReady            = memoryReady & reqI;
        end
        BUSY_D: begin
          memoryAddress     = dAddress;
          memoryReadEnable  = dReadEnable;
          memoryWriteEnable = dWriteEnable;
          memoryDataOut     = dDataIn;
          dReady            = memoryReady & reqD;
          grantD            = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus randomized traffic from both caches,
// checked by a per-port transaction scoreboard and a bounded-starvation rule.
`timescale 1ns/1ps
module tb_memory_arbiter;
  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        resetN;
  logic [31:0] iAddress, iDataIn, iDataOut;
  logic        iReadEnable, iWriteEnable, iReady;
  logic [31:0] dAddress, dDataIn, dDataOut;
  logic        dReadEnable, dWriteEnable, dReady;
  logic [31:0] memoryAddress, memoryDataOut, memoryDataIn;
  logic        memoryReadEnable, memoryWriteEnable, memoryReady;
  logic        grantD;

  always #5 clk = ~clk;

  memory_arbiter #(.MAX_DATA_STREAK(MAXS), .STREAK_W(3)) dut (
    .clk(clk), .resetN(resetN),
    .iAddress(iAddress), .iReadEnable(iReadEnable), .iWriteEnable(iWriteEnable),
    .iDataIn(iDataIn), .iDataOut(iDataOut), .iReady(iReady),
    .dAddress(dAddress), .dReadEnable(dReadEnable), .dWriteEnable(dWriteEnable),
    .dDataIn(dDataIn), .dDataOut(dDataOut), .dReady(dReady),
    .memoryAddress(memoryAddress), .memoryReadEnable(memoryReadEnable),
    .memoryWriteEnable(memoryWriteEnable), .memoryDataOut(memoryDataOut),
    .memoryDataIn(memoryDataIn), .memoryReady(memoryReady), .grantD(grantD)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign memoryDataIn = memWord(memoryAddress);

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t iQ[$];
  txn_t dQ[$];

  int tests  = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic checkTxn(input string p, input txn_t e, input logic [31:0] rdata, input logic expGrant);
    chk({p, "_addr"}, memoryAddress, e.addr);
    chk({p, "_we"}, 32'(memoryWriteEnable), 32'(e.wr));
    chk({p, "_re"}, 32'(memoryReadEnable), 32'(!e.wr));
    if (e.wr) chk({p, "_wdata"}, memoryDataOut, e.data);
    else      chk({p, "_rdata"}, rdata, e.data);
    chk({p, "_grantD"}, 32'(grantD), 32'(expGrant));
  endtask

  // Memory model: fixed or random latency counted from the first strobed cycle.
  bit memAuto = 1'b0;
  bit memRand = 1'b0;
  int memLat  = 0;
  int memCnt  = 0;

  always @(posedge clk) begin
    #2;
    if (memAuto) begin
      if (memoryReadEnable || memoryWriteEnable) begin
        if (memCnt == 0) memoryReady = 1'b1;
        else begin
          memoryReady = 1'b0;
          memCnt--;
        end
      end else begin
        memoryReady = 1'b0;
        memCnt = memRand ? int'($urandom_range(0, 3)) : memLat;
      end
    end
  end

  // Monitor: pops the expected transfer for whichever port reports ready.
  bit monOn  = 1'b0;
  int iWaitD = 0;

  always @(negedge clk) begin
    txn_t e;
    if (monOn) begin
      if (iReady || dReady) chk("ready_exclusive", 32'(iReady & dReady), 32'd0);
      if (iReady) begin
        tests++;
        if (iQ.size() == 0) begin
          errors++;
          $display("FAIL unexpected_iReady: got a ready pulse, expected no pending I transfer");
        end else begin
          e = iQ.pop_front();
          checkTxn("I", e, iDataOut, 1'b0);
        end
      end
      if (dReady) begin
        tests++;
        if (dQ.size() == 0) begin
          errors++;
          $display("FAIL unexpected_dReady: got a ready pulse, expected no pending D transfer");
        end else begin
          e = dQ.pop_front();
          checkTxn("D", e, dDataOut, 1'b1);
        end
      end
      // I may see the in-flight D transfer finish plus MAXS more before it is served.
      if (iReadEnable || iWriteEnable) begin
        if (dReady) begin
          iWaitD++;
          chk("i_starvation_bound", 32'(iWaitD <= MAXS + 1), 32'd1);
        end
        if (iReady) iWaitD = 0;
      end else iWaitD = 0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady(input bit isD, input int budget, input string nm, output int cyc);
    cyc = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (isD ? dReady : iReady) begin
        cyc = n;
        break;
      end
    end
    if (cyc < 0) begin
      tests++;
      errors++;
      $display("FAIL %s_timeout: got no ready within %0d cycles, expected a ready", nm, budget);
    end
  endtask

  function automatic txn_t mkRead(input logic [31:0] a);
    txn_t e;
    e.wr = 1'b0; e.addr = a; e.data = memWord(a);
    return e;
  endfunction

  task automatic requester(input bit isD, input int num);
    for (int k = 0; k < num; k++) begin
      txn_t e;
      int cyc, gap;
      e.wr   = 1'($urandom_range(0, 1));
      e.addr = $urandom;
      e.data = e.wr ? $urandom : memWord(e.addr);
      if (isD) begin
        dQ.push_back(e);
        dAddress = e.addr; dDataIn = e.data;
        dWriteEnable = e.wr; dReadEnable = !e.wr;
      end else begin
        iQ.push_back(e);
        iAddress = e.addr; iDataIn = e.data;
        iWriteEnable = e.wr; iReadEnable = !e.wr;
      end
      waitReady(isD, 200, isD ? "rand_d" : "rand_i", cyc);
      tick;
      gap = $urandom_range(0, 3);
      if (gap > 0 || k == num - 1) begin
        if (isD) begin dReadEnable = 1'b0; dWriteEnable = 1'b0; end
        else     begin iReadEnable = 1'b0; iWriteEnable = 1'b0; end
        repeat (gap) tick;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, dAt, iAt, r0, r1, cnt;
    logic g1;
    bit found;
    string seq;

    resetN = 1'b0;
    iAddress = 32'h0; iDataIn = 32'h0; iReadEnable = 1'b1; iWriteEnable = 1'b0;
    dAddress = 32'h10; dDataIn = 32'h0; dReadEnable = 1'b1; dWriteEnable = 1'b0;
    memoryReady = 1'b1;

    // Reset with both requests high
    repeat (2) tick;
    @(negedge clk);
    chk("rst_re", 32'(memoryReadEnable), 32'd0);
    chk("rst_we", 32'(memoryWriteEnable), 32'd0);
    chk("rst_iReady", 32'(iReady), 32'd0);
    chk("rst_dReady", 32'(dReady), 32'd0);
    chk("rst_grantD", 32'(grantD), 32'd0);
    chk("rst_addr", memoryAddress, 32'h0);
    resetN = 1'b1;
    memoryReady = 1'b0;
    @(negedge clk);
    chk("post_rst_d_priority", 32'(grantD), 32'd1);
    chk("post_rst_d_addr", memoryAddress, 32'h10);
    tick;
    iReadEnable = 1'b0; dReadEnable = 1'b0;
    repeat (3) tick;
    monOn = 1'b1;
    memAuto = 1'b1;

    // Single I read, memory 3 cycles after strobe
    memLat = 3;
    iAddress = 32'h40; iReadEnable = 1'b1;
    iQ.push_back(mkRead(32'h40));
    @(negedge clk);
    chk("i_idle_no_strobe", 32'(memoryReadEnable), 32'd0);
    tick;
    @(negedge clk);
    chk("i_busy_addr", memoryAddress, 32'h40);
    chk("i_busy_re", 32'(memoryReadEnable), 32'd1);
    chk("i_busy_not_ready", 32'(iReady), 32'd0);
    waitReady(1'b0, 10, "single_i", cyc);
    chk("i_ready_latency", 32'(cyc + 1), 32'd3);
    chk("i_read_data", iDataOut, memWord(32'h40));
    tick;
    iReadEnable = 1'b0;
    @(negedge clk);
    chk("release_re", 32'(memoryReadEnable), 32'd0);
    chk("release_iReady", 32'(iReady), 32'd0);
    repeat (2) tick;

    // Contention: D first, I in the IDLE after D's RELEASE
    memLat = 1;
    dAddress = 32'h90; iAddress = 32'h80;
    dQ.push_back(mkRead(32'h90));
    iQ.push_back(mkRead(32'h80));
    dReadEnable = 1'b1; iReadEnable = 1'b1;
    dAt = -1; iAt = -1; g1 = 1'b0;
    for (int n = 0; n < 40 && (dAt < 0 || iAt < 0); n++) begin
      @(negedge clk);
      if (n == 1) g1 = grantD;
      if (dReady) dAt = n;
      if (iReady) iAt = n;
      tick;
      if (dAt == n) dReadEnable = 1'b0;
      if (iAt == n) iReadEnable = 1'b0;
    end
    dReadEnable = 1'b0; iReadEnable = 1'b0;
    chk("contention_grantD", 32'(g1), 32'd1);
    chk("contention_d_first", 32'(dAt >= 0 && iAt > dAt), 32'd1);
    chk("contention_i_gap", 32'(iAt - dAt), 32'd4);
    repeat (2) tick;

    // Starvation: both held, pattern of completions
    memLat = 0;
    dAddress = 32'h200; iAddress = 32'h300;
    for (int k = 0; k < 8; k++) dQ.push_back(mkRead(32'h200));
    for (int k = 0; k < 2; k++) iQ.push_back(mkRead(32'h300));
    dReadEnable = 1'b1; iReadEnable = 1'b1;
    seq = "";
    for (int n = 0; n < 100 && seq.len() < 10; n++) begin
      @(negedge clk);
      if (dReady) seq = {seq, "D"};
      if (iReady) seq = {seq, "I"};
      tick;
    end
    dReadEnable = 1'b0; iReadEnable = 1'b0;
    tests++;
    if (seq != "DDDDIDDDDI") begin
      errors++;
      $display("FAIL starvation_order: got %s, expected DDDDIDDDDI", seq);
    end
    repeat (3) tick;

    // Abort: D drops its request while memoryReady is high
    memAuto = 1'b0;
    memoryReady = 1'b0;
    dAddress = 32'h500; dReadEnable = 1'b1;
    tick;
    dReadEnable = 1'b0;
    memoryReady = 1'b1;
    @(negedge clk);
    chk("abort_grantD", 32'(grantD), 32'd1);
    chk("abort_dReady", 32'(dReady), 32'd0);
    chk("abort_re", 32'(memoryReadEnable), 32'd0);
    tick;
    memoryReady = 1'b0;
    @(negedge clk);
    chk("abort_release_grantD", 32'(grantD), 32'd0);
    chk("abort_release_dReady", 32'(dReady), 32'd0);
    tick;
    memAuto = 1'b1; memLat = 1;
    iAddress = 32'h600; iReadEnable = 1'b1;
    iQ.push_back(mkRead(32'h600));
    waitReady(1'b0, 10, "after_abort_i", cyc);
    chk("after_abort_i_latency", 32'(cyc), 32'd2);
    tick;
    iReadEnable = 1'b0;
    repeat (2) tick;

    // Address change between two D word reads
    memLat = 2;
    dQ.push_back(mkRead(32'h103));
    dQ.push_back(mkRead(32'h107));
    dAddress = 32'h103; dReadEnable = 1'b1;
    r0 = -1; r1 = -1; cnt = 0;
    for (int n = 0; n < 40 && cnt < 2; n++) begin
      @(negedge clk);
      if (grantD) chk("addr_follow", memoryAddress, dAddress);
      if (dReady) begin
        if (cnt == 0) r0 = n; else r1 = n;
        cnt++;
      end
      tick;
      if (cnt == 1) dAddress = 32'h107;
    end
    dReadEnable = 1'b0;
    chk("addr_first_ready", 32'(r0), 32'd3);
    chk("addr_gap", 32'(r1 - r0), 32'd5);
    repeat (2) tick;

    // Reset in the middle of an I transfer
    memLat = 3;
    iAddress = 32'h700; iReadEnable = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      @(negedge clk);
      if (memoryReadEnable) found = 1'b1;
    end
    chk("midrst_reached_busy", 32'(found), 32'd1);
    tick;
    resetN = 1'b0;
    memAuto = 1'b0;
    memoryReady = 1'b1;
    @(negedge clk);
    chk("midrst_iReady", 32'(iReady), 32'd0);
    chk("midrst_re", 32'(memoryReadEnable), 32'd0);
    tick;
    resetN = 1'b1;
    @(negedge clk);
    chk("midrst_idle_iReady", 32'(iReady), 32'd0);
    chk("midrst_idle_re", 32'(memoryReadEnable), 32'd0);
    iQ.push_back(mkRead(32'h700));
    waitReady(1'b0, 5, "midrst_regrant", cyc);
    chk("midrst_regrant_latency", 32'(cyc), 32'd0);
    tick;
    iReadEnable = 1'b0;
    memoryReady = 1'b0;
    repeat (2) tick;

    // Randomized traffic from both caches
    memAuto = 1'b1;
    memRand = 1'b1;
    fork
      requester(1'b0, 40);
      requester(1'b1, 40);
    join
    repeat (3) tick;
    chk("iQ_drained", 32'(iQ.size()), 32'd0);
    chk("dQ_drained", 32'(dQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
